night_cycle_ctrl: RTL



---
 rtl/night_cycle_pkg.sv | 26 ++
 rtl/night_cycle_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/night_cycle_pkg.sv
// Shared types and constants for the day/night cycle controller and the
// night sky block that consumes night_rate.
package night_cycle_pkg;

  typedef enum logic [1:0] {
    DAY      = 2'd0,
    FADE_IN  = 2'd1,
    NIGHT    = 2'd2,
    FADE_OUT = 2'd3
  } night_state_t;

  localparam int unsigned RATE_W  = 6;
  localparam int unsigned THR_W   = 18;
  localparam int unsigned SCORE_W = 17;
  localparam int unsigned HOLD_W  = 16;

  localparam int unsigned MAX_RATE = 63;

  localparam int unsigned DEF_NIGHT_INTERVAL = 700;
  localparam int unsigned DEF_RATE_STEP      = 4;
  localparam int unsigned DEF_HOLD_FRAMES    = 600;

  // Rate above which the night sky is drawn; the palette inverter uses the same point.
  localparam int unsigned VISIBLE_RATE = 32;

endpackage

// File: rtl/night_cycle_ctrl.sv
// Day/night cycle sequencer: fades night_rate up, holds it, and fades back
// each time the score crosses the next multiple of NIGHT_INTERVAL.
module night_cycle_ctrl
  import night_cycle_pkg::*;
#(
  parameter int unsigned NIGHT_INTERVAL = DEF_NIGHT_INTERVAL,
  parameter int unsigned RATE_STEP      = DEF_RATE_STEP,
  parameter int unsigned HOLD_FRAMES    = DEF_HOLD_FRAMES,
  parameter int unsigned INVERT_RATE    = VISIBLE_RATE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic               crash,
  input  logic [SCORE_W-1:0] score,
  output logic [RATE_W-1:0]  night_rate,
  output logic               night_active,
  output logic               invert,
  output logic [1:0]         state_o
);

  localparam logic [RATE_W-1:0] STEP6     = RATE_W'(RATE_STEP);
  localparam logic [RATE_W:0]   MAX7      = (RATE_W + 1)'(MAX_RATE);
  localparam logic [RATE_W:0]   INV7      = (RATE_W + 1)'(INVERT_RATE);
  localparam logic [THR_W-1:0]  INTV      = THR_W'(NIGHT_INTERVAL);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  night_state_t      r_state;
  logic [RATE_W-1:0] r_rate;
  logic              r_active;
  logic              r_invert;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [THR_W-1:0]  r_next_thr;

  logic [RATE_W-1:0] w_rate_up;
  logic [RATE_W-1:0] w_rate_dn;
  logic [THR_W-1:0]  w_thr_adv;
  logic              w_score_hit;

  function automatic logic [RATE_W-1:0] rate_up(input logic [RATE_W-1:0] r);
    logic [RATE_W:0] s;
    s = {1'b0, r} + {1'b0, STEP6};
    return (s > MAX7) ? MAX7[RATE_W-1:0] : s[RATE_W-1:0];
  endfunction

  function automatic logic [RATE_W-1:0] rate_down(input logic [RATE_W-1:0] r);
    logic signed [RATE_W+1:0] d;
    d = $signed({2'b00, r}) - $signed({2'b00, STEP6});
    return (d < 0) ? '0 : d[RATE_W-1:0];
  endfunction

  // Threshold saturates instead of wrapping so a huge score can never re-arm early.
  function automatic logic [THR_W-1:0] thr_advance(input logic [THR_W-1:0] t);
    logic [THR_W:0] s;
    s = {1'b0, t} + {1'b0, INTV};
    return s[THR_W] ? '1 : s[THR_W-1:0];
  endfunction

  assign w_rate_up   = rate_up(r_rate);
  assign w_rate_dn   = rate_down(r_rate);
  assign w_thr_adv   = thr_advance(r_next_thr);
  assign w_score_hit = ({1'b0, score} >= r_next_thr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DAY;
      r_rate     <= '0;
      r_active   <= 1'b0;
      r_invert   <= 1'b0;
      r_hold_cnt <= '0;
      r_next_thr <= INTV;
    end else if (update && !crash) begin
      // Crossings while a night is already running are dropped, one interval per update.
      if (r_state != DAY && w_score_hit) begin
        r_next_thr <= w_thr_adv;
      end
      case (r_state)
        DAY: begin
          if (w_score_hit) begin
            r_state    <= FADE_IN;
            r_active   <= 1'b1;
            r_next_thr <= w_thr_adv;
          end
        end
        FADE_IN: begin
          r_rate   <= w_rate_up;
          r_invert <= ({1'b0, w_rate_up} > INV7);
          if ({1'b0, w_rate_up} == MAX7) begin
            r_state    <= NIGHT;
            r_hold_cnt <= '0;
          end
        end
        NIGHT: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= FADE_OUT;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        FADE_OUT: begin
          r_rate   <= w_rate_dn;
          r_invert <= ({1'b0, w_rate_dn} > INV7);
          if (w_rate_dn == '0) begin
            r_state  <= DAY;
            r_active <= 1'b0;
          end
        end
        default: r_state <= DAY;
      endcase
    end
  end

  assign night_rate   = r_rate;
  assign night_active = r_active;
  assign invert       = r_invert;
  assign state_o      = r_state;

endmodule
